// File: rtl/spi_pkg.sv
// Shared SPI definitions: master FSM encoding, mode constants, defaults and the
// command codes understood by the slave-side message interpreter.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOW,
    ST_HIGH,
    ST_GAP,
    ST_HOLD,
    ST_DONE
  } spi_state_e;

  // Mode 0: SCK idles low, data sampled on the rising edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  localparam int SPI_BYTE_W            = 8;
  localparam int SPI_CLK_DIV_DEFAULT   = 25;
  localparam int SPI_MAX_BYTES_DEFAULT = 3;

  localparam logic [7:0] SPI_CMD_NOP         = 8'h00;
  localparam logic [7:0] SPI_CMD_READ_STATUS = 8'h12;
  localparam logic [7:0] SPI_CMD_READ_IMU    = 8'h21;
  localparam logic [7:0] SPI_CMD_READ_ENC    = 8'h22;
  localparam logic [7:0] SPI_CMD_SET_MOTOR   = 8'h30;
  localparam logic [7:0] SPI_CMD_ECHO        = 8'hF0;

  function automatic logic [1:0] clamp_nbytes(input logic [1:0] nb, input int max_b);
    if (int'(nb) > max_b) return 2'(max_b);
    return nb;
  endfunction

endpackage

// File: rtl/spi_master_baud.sv
// Half-period tick generator: pulses tick every CLK_DIV clocks, restartable by clr.
module spi_master_baud #(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CW'(CLK_DIV - 1));
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_master_transaction.sv
// Mode-0 SPI master: one command byte out, then 0..MAX_BYTES response bytes in,
// framed by a single SS low period.
module spi_master_transaction
  import spi_pkg::*;
#(
  parameter int DATAWIDTH_BUS = SPI_BYTE_W,
  parameter int CLK_DIV       = SPI_CLK_DIV_DEFAULT,
  parameter int MAX_BYTES     = SPI_MAX_BYTES_DEFAULT
) (
  input  logic                             SPI_MASTER_CLOCK_50,
  input  logic                             SPI_MASTER_RESET_InHigh,
  input  logic                             SPI_MASTER_START_In,
  input  logic [DATAWIDTH_BUS-1:0]         SPI_MASTER_CMD_InBus,
  input  logic [1:0]                       SPI_MASTER_NBYTES_InBus,
  input  logic                             SPI_MASTER_MISO_In,
  output logic                             SPI_MASTER_SCK_Out,
  output logic                             SPI_MASTER_MOSI_Out,
  output logic                             SPI_MASTER_SS_OutLow,
  output logic                             SPI_MASTER_BUSY_Out,
  output logic                             SPI_MASTER_DONE_Out,
  output logic [MAX_BYTES*DATAWIDTH_BUS-1:0] SPI_MASTER_DATA_OutBus
);

  localparam int RXW = MAX_BYTES * DATAWIDTH_BUS;
  localparam int BCW = $clog2(DATAWIDTH_BUS);
  localparam int DW  = DATAWIDTH_BUS;

  spi_state_e         state_q, state_d;
  logic [DW-1:0]      shift_q, shift_d;
  logic [RXW-1:0]     rx_q, rx_d;
  logic [RXW-1:0]     data_q, data_d;
  logic [BCW-1:0]     bit_q, bit_d;
  logic [1:0]         left_q, left_d;
  logic               resp_q, resp_d;
  logic               gap_half_q, gap_half_d;

  logic baud_clr, tick;
  logic sck_c, mosi_c, ss_n_c, busy_c, done_c;

  spi_master_baud #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk  (SPI_MASTER_CLOCK_50),
    .rst  (SPI_MASTER_RESET_InHigh),
    .clr  (baud_clr),
    .tick (tick)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    rx_d       = rx_q;
    data_d     = data_q;
    bit_d      = bit_q;
    left_d     = left_q;
    resp_d     = resp_q;
    gap_half_d = gap_half_q;
    baud_clr   = 1'b0;
    sck_c      = SPI_CPOL;
    mosi_c     = 1'b0;
    ss_n_c     = 1'b0;
    busy_c     = 1'b1;
    done_c     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ss_n_c   = 1'b1;
        busy_c   = 1'b0;
        baud_clr = 1'b1;
        if (SPI_MASTER_START_In) begin
          state_d    = ST_SETUP;
          shift_d    = SPI_MASTER_CMD_InBus;
          rx_d       = '0;
          bit_d      = '0;
          left_d     = clamp_nbytes(SPI_MASTER_NBYTES_InBus, MAX_BYTES);
          resp_d     = 1'b0;
          gap_half_d = 1'b0;
        end
      end
      ST_SETUP: begin
        mosi_c = shift_q[DW-1];
        if (tick) state_d = ST_HIGH;
      end
      ST_HIGH: begin
        sck_c  = 1'b1;
        mosi_c = shift_q[DW-1];
        if (tick) begin
          if (bit_q != BCW'(DW - 1)) begin
            state_d = ST_LOW;
            bit_d   = bit_q + 1'b1;
            shift_d = {shift_q[DW-2:0], 1'b0};
          end else if (left_q != 2'd0) begin
            // Every byte after the command is a response byte clocking out 0x00.
            state_d = ST_GAP;
            bit_d   = '0;
            left_d  = left_q - 2'd1;
            shift_d = '0;
            resp_d  = 1'b1;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_LOW: begin
        mosi_c = shift_q[DW-1];
        if (tick) state_d = ST_HIGH;
      end
      ST_GAP: begin
        mosi_c = shift_q[DW-1];
        if (tick) begin
          gap_half_d = ~gap_half_q;
          if (gap_half_q) state_d = ST_HIGH;
        end
      end
      ST_HOLD: begin
        if (tick) begin
          state_d = ST_DONE;
          data_d  = rx_q;
        end
      end
      ST_DONE: begin
        ss_n_c   = 1'b1;
        busy_c   = 1'b0;
        done_c   = 1'b1;
        baud_clr = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // MISO is captured on the clock SCK rises; command-byte bits are dropped.
    if (tick && resp_q && state_d == ST_HIGH && state_q != ST_HIGH)
      rx_d = {rx_q[RXW-2:0], SPI_MASTER_MISO_In};
  end

  always_ff @(posedge SPI_MASTER_CLOCK_50 or posedge SPI_MASTER_RESET_InHigh) begin
    if (SPI_MASTER_RESET_InHigh) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      rx_q       <= '0;
      data_q     <= '0;
      bit_q      <= '0;
      left_q     <= '0;
      resp_q     <= 1'b0;
      gap_half_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      rx_q       <= rx_d;
      data_q     <= data_d;
      bit_q      <= bit_d;
      left_q     <= left_d;
      resp_q     <= resp_d;
      gap_half_q <= gap_half_d;
    end
  end

  // Reset forces the idle levels combinationally so they apply in the same cycle.
  assign SPI_MASTER_SCK_Out     = SPI_MASTER_RESET_InHigh ? SPI_CPOL : sck_c;
  assign SPI_MASTER_MOSI_Out    = SPI_MASTER_RESET_InHigh ? 1'b0     : mosi_c;
  assign SPI_MASTER_SS_OutLow   = SPI_MASTER_RESET_InHigh ? 1'b1     : ss_n_c;
  assign SPI_MASTER_BUSY_Out    = SPI_MASTER_RESET_InHigh ? 1'b0     : busy_c;
  assign SPI_MASTER_DONE_Out    = SPI_MASTER_RESET_InHigh ? 1'b0     : done_c;
  assign SPI_MASTER_DATA_OutBus = data_q;

endmodule

// File: tb/tb_spi_master_transaction.sv
// Bench for spi_master_transaction: queue-driven mode-0 slave model, bus monitor
// and per-scenario tasks comparing against a transaction-level reference model.
module tb_spi_master_transaction;

  localparam int C  = 25;
  localparam int DW = 8;
  localparam int MB = 3;

  logic          clk, rst, start, miso;
  logic [7:0]    cmd;
  logic [1:0]    nb;
  logic          sck, mosi, ss_n, busy, done;
  logic [23:0]   data;

  int total = 0;
  int bad   = 0;

  logic miso_q[$];
  logic mosi_q[$];
  int   lows[$];
  int   rises, low_run, done_cnt, ss_low_cycles, mosi_hi_chg, mosi_age, min_age;
  logic prev_sck, prev_mosi;

  spi_master_transaction #(.DATAWIDTH_BUS(DW), .CLK_DIV(C), .MAX_BYTES(MB)) dut (
    .SPI_MASTER_CLOCK_50     (clk),
    .SPI_MASTER_RESET_InHigh (rst),
    .SPI_MASTER_START_In     (start),
    .SPI_MASTER_CMD_InBus    (cmd),
    .SPI_MASTER_NBYTES_InBus (nb),
    .SPI_MASTER_MISO_In      (miso),
    .SPI_MASTER_SCK_Out      (sck),
    .SPI_MASTER_MOSI_Out     (mosi),
    .SPI_MASTER_SS_OutLow    (ss_n),
    .SPI_MASTER_BUSY_Out     (busy),
    .SPI_MASTER_DONE_Out     (done),
    .SPI_MASTER_DATA_OutBus  (data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Mode-0 slave: next bit presented on SS fall and on every SCK fall.
  initial begin
    miso = 1'b0;
    forever begin
      @(negedge sck or negedge ss_n);
      if (miso_q.size() > 0) miso = miso_q.pop_front();
      else                   miso = 1'b0;
    end
  end

  // Bus monitor, sampled on the falling clock edge.
  initial begin
    prev_sck = 1'b0; prev_mosi = 1'b0; mosi_age = 1000; min_age = 1000;
    rises = 0; low_run = 0; done_cnt = 0; ss_low_cycles = 0; mosi_hi_chg = 0;
    forever begin
      @(negedge clk);
      if (ss_n === 1'b0) ss_low_cycles++;
      if (done === 1'b1) done_cnt++;
      if (mosi !== prev_mosi) mosi_age = 0;
      else                    mosi_age++;
      if (sck && prev_sck && mosi !== prev_mosi) mosi_hi_chg++;
      if (sck && !prev_sck) begin
        rises++;
        mosi_q.push_back(mosi);
        lows.push_back(low_run);
        low_run = 0;
        if (mosi_age < min_age) min_age = mosi_age;
      end else if (!sck && ss_n === 1'b0) begin
        low_run++;
      end
      prev_sck  = sck;
      prev_mosi = mosi;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [23:0] exp_data(input logic [1:0] n, input logic [23:0] resp);
    logic [23:0] e = '0;
    for (int i = 0; i < int'(n); i++) e = {e[15:0], resp[23-8*i -: 8]};
    return e;
  endfunction

  // START-to-DONE cycles: launch, setup, 8 high + 7 low per byte, gaps, hold.
  function automatic int exp_len(input logic [1:0] n);
    int b = int'(n) + 1;
    return 1 + C + b * (8 + 7) * C + (b - 1) * 2 * C + C;
  endfunction

  function automatic logic [7:0] mosi_byte(input int i);
    logic [7:0] b = '0;
    for (int k = 0; k < 8; k++)
      if (8*i + k < mosi_q.size()) b = {b[6:0], mosi_q[8*i+k]};
    return b;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_slave(input logic [1:0] n, input logic [23:0] resp);
    for (int k = 0; k < 8; k++) miso_q.push_back(1'($urandom_range(0, 1)));
    for (int i = 0; i < int'(n); i++)
      for (int k = 0; k < 8; k++) miso_q.push_back(resp[23 - 8*i - k]);
    miso_q.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic clear_stats();
    mosi_q.delete(); lows.delete();
    rises = 0; low_run = 0; done_cnt = 0; ss_low_cycles = 0; mosi_hi_chg = 0;
    min_age = 1000;
  endtask

  task automatic run_txn(input logic [7:0] c, input logic [1:0] n, input logic [23:0] resp,
                         input int poke_at, output int len, output logic lat_ok);
    push_slave(n, resp);
    @(negedge clk);
    clear_stats();
    cmd = c; nb = n; start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    lat_ok = (ss_n === 1'b0) && (busy === 1'b1);
    len = 1;
    while (done !== 1'b1 && len < 5000) begin
      @(negedge clk);
      len++;
      if (len == poke_at) begin start = 1'b1; cmd = 8'h55; nb = 2'd0; end
      else start = 1'b0;
    end
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    total++; if (ss_n !== 1'b1)  begin bad++; $display("FAIL reset_ss got=%b exp=1", ss_n); end
    total++; if (sck !== 1'b0)   begin bad++; $display("FAIL reset_sck got=%b exp=0", sck); end
    total++; if (mosi !== 1'b0)  begin bad++; $display("FAIL reset_mosi got=%b exp=0", mosi); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
    total++; if (data !== 24'h0) begin bad++; $display("FAIL reset_data got=%h exp=000000", data); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_cmd_only();
    int len; logic lat;
    run_txn(8'hF0, 2'd0, 24'hFFFFFF, -1, len, lat);
    total++; if (rises !== 8) begin bad++; $display("FAIL cmd_only_rises got=%0d exp=8", rises); end
    total++; if (data !== 24'h0) begin bad++; $display("FAIL cmd_only_data got=%h exp=000000", data); end
    total++; if (len !== 426) begin bad++; $display("FAIL cmd_only_len got=%0d exp=426", len); end
    total++; if (mosi_byte(0) !== 8'hF0) begin bad++; $display("FAIL cmd_only_mosi got=%h exp=f0", mosi_byte(0)); end
    total++; if (!lat) begin bad++; $display("FAIL start_latency got=0 exp=1"); end
  endtask

  task automatic test_one_byte();
    int len; logic lat;
    run_txn(8'h21, 2'd1, 24'h7E0000, -1, len, lat);
    total++; if (data !== 24'h00007E) begin bad++; $display("FAIL one_byte_data got=%h exp=00007e", data); end
    total++;
    if (lows.size() < 9 || lows[8] !== 2*C) begin
      bad++; $display("FAIL one_byte_gap got=%0d exp=%0d", (lows.size() < 9) ? -1 : lows[8], 2*C);
    end
    total++; if (lows.size() < 1 || lows[0] !== C) begin bad++; $display("FAIL one_byte_setup got=%0d exp=%0d", (lows.size() < 1) ? -1 : lows[0], C); end
    total++; if (len !== exp_len(2'd1)) begin bad++; $display("FAIL one_byte_len got=%0d exp=%0d", len, exp_len(2'd1)); end
  endtask

  task automatic test_loopback();
    int len; logic lat;
    run_txn(8'h12, 2'd3, 24'hA53C81, -1, len, lat);
    total++; if (data !== 24'hA53C81) begin bad++; $display("FAIL loop_data got=%h exp=a53c81", data); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL loop_done_pulses got=%0d exp=1", done_cnt); end
    total++; if (ss_low_cycles !== exp_len(2'd3) - 1) begin bad++; $display("FAIL loop_ss_low got=%0d exp=%0d", ss_low_cycles, exp_len(2'd3) - 1); end
    total++; if (len !== exp_len(2'd3)) begin bad++; $display("FAIL loop_len got=%0d exp=%0d", len, exp_len(2'd3)); end
    total++; if (rises !== 32) begin bad++; $display("FAIL loop_rises got=%0d exp=32", rises); end
    total++;
    if (mosi_byte(0) !== 8'h12 || mosi_byte(1) !== 8'h00 || mosi_byte(2) !== 8'h00 || mosi_byte(3) !== 8'h00) begin
      bad++; $display("FAIL loop_mosi got=%h%h%h%h exp=12000000", mosi_byte(0), mosi_byte(1), mosi_byte(2), mosi_byte(3));
    end
    total++; if (mosi_hi_chg !== 0) begin bad++; $display("FAIL loop_mosi_in_high got=%0d exp=0", mosi_hi_chg); end
    total++; if (min_age < C) begin bad++; $display("FAIL loop_mosi_setup got=%0d exp>=%0d", min_age, C); end
  endtask

  task automatic test_start_ignored();
    int len; logic lat;
    run_txn(8'h30, 2'd2, 24'h5AC300, 120, len, lat);
    total++; if (mosi_byte(0) !== 8'h30) begin bad++; $display("FAIL ignored_cmd got=%h exp=30", mosi_byte(0)); end
    total++; if (rises !== 24) begin bad++; $display("FAIL ignored_rises got=%0d exp=24", rises); end
    total++; if (data !== 24'h005AC3) begin bad++; $display("FAIL ignored_data got=%h exp=005ac3", data); end
    total++; if (busy !== 1'b0 || ss_n !== 1'b1) begin bad++; $display("FAIL ignored_restart got=%b%b exp=01", busy, ss_n); end
  endtask

  task automatic test_random();
    int len; logic lat;
    logic [7:0] c; logic [1:0] n; logic [23:0] r;
    for (int t = 0; t < 6; t++) begin
      c = 8'($urandom_range(0, 255));
      n = 2'($urandom_range(0, 3));
      r = 24'($urandom);
      run_txn(c, n, r, -1, len, lat);
      total++; if (data !== exp_data(n, r)) begin bad++; $display("FAIL rand_data[%0d] got=%h exp=%h", t, data, exp_data(n, r)); end
      total++; if (len !== exp_len(n)) begin bad++; $display("FAIL rand_len[%0d] got=%0d exp=%0d", t, len, exp_len(n)); end
      total++; if (rises !== 8 * (int'(n) + 1)) begin bad++; $display("FAIL rand_rises[%0d] got=%0d exp=%0d", t, rises, 8 * (int'(n) + 1)); end
      total++; if (mosi_byte(0) !== c) begin bad++; $display("FAIL rand_cmd[%0d] got=%h exp=%h", t, mosi_byte(0), c); end
    end
  endtask

  task automatic test_reset_mid();
    int k, len; logic lat; logic [23:0] r;
    r = 24'($urandom);
    push_slave(2'd2, r);
    @(negedge clk);
    clear_stats();
    cmd = 8'h22; nb = 2'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (rises < 10 && k < 3000) begin @(negedge clk); k++; end
    total++; if (k >= 3000) begin bad++; $display("FAIL rmid_timeout got=%0d exp<3000", k); end
    rst = 1'b1;
    #1;
    total++; if (ss_n !== 1'b1 || sck !== 1'b0) begin bad++; $display("FAIL rmid_ss_sck got=%b%b exp=10", ss_n, sck); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    total++; if (data !== 24'h0) begin bad++; $display("FAIL rmid_data got=%h exp=000000", data); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    miso_q.delete();
    r = 24'($urandom);
    run_txn(8'hC7, 2'd2, r, -1, len, lat);
    total++; if (data !== exp_data(2'd2, r)) begin bad++; $display("FAIL rmid_clean_data got=%h exp=%h", data, exp_data(2'd2, r)); end
    total++; if (mosi_byte(0) !== 8'hC7 || len !== exp_len(2'd2)) begin bad++; $display("FAIL rmid_clean_txn got=%h/%0d exp=c7/%0d", mosi_byte(0), len, exp_len(2'd2)); end
  endtask

  task automatic test_back_to_back();
    int k; logic [23:0] r1, r2;
    r1 = 24'($urandom); r2 = 24'($urandom);
    push_slave(2'd2, r1);
    push_slave(2'd2, r2);
    @(negedge clk);
    clear_stats();
    cmd = 8'h12; nb = 2'd2; start = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (done !== 1'b1 && k < 5000);
    total++; if (data !== exp_data(2'd2, r1)) begin bad++; $display("FAIL b2b_data1 got=%h exp=%h", data, exp_data(2'd2, r1)); end
    @(negedge clk);
    total++; if (busy !== 1'b0 || ss_n !== 1'b1) begin bad++; $display("FAIL b2b_idle got=%b%b exp=01", busy, ss_n); end
    @(negedge clk);
    total++; if (busy !== 1'b1 || ss_n !== 1'b0) begin bad++; $display("FAIL b2b_restart got=%b%b exp=10", busy, ss_n); end
    start = 1'b0;
    repeat (200) @(negedge clk);
    total++; if (data !== exp_data(2'd2, r1)) begin bad++; $display("FAIL b2b_hold got=%h exp=%h", data, exp_data(2'd2, r1)); end
    k = 0;
    while (done !== 1'b1 && k < 5000) begin @(negedge clk); k++; end
    total++; if (data !== exp_data(2'd2, r2)) begin bad++; $display("FAIL b2b_data2 got=%h exp=%h", data, exp_data(2'd2, r2)); end
    @(negedge clk);
    total++; if (done_cnt !== 2 || rises !== 48) begin bad++; $display("FAIL b2b_counts got=%0d/%0d exp=2/48", done_cnt, rises); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cmd = 8'h00; nb = 2'd0;
    repeat (3) @(negedge clk);
    test_reset();
    test_cmd_only();
    test_one_byte();
    test_loopback();
    test_start_ignored();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_master_transaction.md
# spi_master_transaction

Mode-0 SPI master that runs one complete command/response transaction: it drives SS low, shifts out one command byte, clocks in 0–3 response bytes, then releases SS. It is the initiator for the robot's SPI slave port. The block serves as the on-board master for SPI peripherals such as the IMU, and as the driver in the slave-port bench. It connects to the system 50 MHz clock and shares command codes with the slave-side message interpreter.

## Interface
- DATAWIDTH_BUS, 8: byte width.
- CLK_DIV, 25: SCK half-period in clocks (25 gives 1 MHz SCK). Legal range is ≥ 8, which leaves room for the slave's SCK synchronizer and MISO update.
- MAX_BYTES, 3: maximum number of response bytes.
- SPI_MASTER_CLOCK_50  in  1  system clock, 50 MHz.
- SPI_MASTER_RESET_InHigh  in  1  reset, asynchronous, active-high.
- SPI_MASTER_START_In  in  1  request; sampled only in IDLE.
- SPI_MASTER_CMD_InBus  in  8  command byte; captured with START.
- SPI_MASTER_NBYTES_InBus  in  2  response byte count; captured with START.
- SPI_MASTER_MISO_In  in  1  serial data from the slave.
- SPI_MASTER_SCK_Out  out  1  serial clock; idle level 0.
- SPI_MASTER_MOSI_Out  out  1  serial data to the slave; MSB first.
- SPI_MASTER_SS_OutLow  out  1  slave select; idle level 1.
- SPI_MASTER_BUSY_Out  out  1  high from START acceptance until DONE.
- SPI_MASTER_DONE_Out  out  1  one-cycle completion pulse.
- SPI_MASTER_DATA_OutBus  out  MAX_BYTES*8  received response, right-justified.

## Operation
- FSM states: IDLE, SETUP, LOW, HIGH, GAP, HOLD, DONE.
- IDLE → SETUP on START.
  - Capture CMD, and NBYTES clamped to MAX_BYTES.
  - Load the shift-out register with CMD. Clear the receive shift register.
  - Byte count = 1 + NBYTES.
- SETUP (CLK_DIV cycles): SS=0, SCK=0, MOSI=CMD[7]. Then go to HIGH.
- HIGH (CLK_DIV cycles): SCK=1. On entry, sample MISO into the receive register, but only for response bytes; MISO during the command byte is discarded.
- Leaving HIGH:
  - If bits remain in the byte: go to LOW.
  - Else if bytes remain: go to GAP.
  - Else: go to HOLD.
- LOW (CLK_DIV cycles): SCK=0. On entry, shift MOSI to the next bit. Then go to HIGH.
- GAP (2*CLK_DIV cycles): SCK=0.
  - Load the next outgoing byte, 0x00; MOSI presents its MSB.
  - Then go to HIGH.
- HOLD (CLK_DIV cycles): SCK=0, SS=0, MOSI=0. Then go to DONE.
- DONE (1 cycle):
  - SS=1, DONE=1, BUSY=0.
  - Load DATA from the receive register; DATA holds until the next DONE.
  - Then go to IDLE.
- Receive register: shifts left and is zero-filled, so the first response byte lands in the most significant used position. Bits above NBYTES*8 read 0.
- NBYTES=0: command-only transaction; DATA=0.

## Timing
- Reset (async, any state) takes effect immediately:
  - SS=1, SCK=0, MOSI=0, BUSY=0, DONE=0, DATA=0.
  - FSM goes to IDLE and all counters clear.
- START latency: SS falls and BUSY rises 1 clock after START is sampled.
- Transaction length from START to DONE is 1 + B·16·CLK_DIV + (B−1)·2·CLK_DIV + CLK_DIV cycles, where B = 1 + NBYTES.
  - With B=1 and CLK_DIV=25 this is 426 cycles.
- MOSI changes only while SCK=0, at least CLK_DIV cycles before each rising edge.
- MISO is sampled on the clock where SCK goes to 1.
- START while BUSY is ignored; a new START is accepted in the IDLE cycle that immediately follows DONE.
- CMD and NBYTES changing mid-transaction have no effect.

## Structure
- Shared package spi_pkg holds:
  - FSM state encoding;
  - SPI mode constants;
  - command codes, shared with the slave-side message interpreter;
  - the default CLK_DIV.
- One sub-module, spi_master_baud: a CLK_DIV tick counter with clear, producing a half-period tick. The FSM owns the shift registers.

## Test plan
- Loopback slave model returns 0xA5, 0x3C, 0x81. CMD=0x12, NBYTES=3 → MOSI stream 0x12,0x00,0x00,0x00; DATA=0xA53C81; one DONE pulse; SS low for exactly the computed cycle count.
- NBYTES=0, CMD=0xF0 → exactly 8 SCK rising edges; DATA=0x000000; 426 cycles for CLK_DIV=25.
- NBYTES=1, slave returns 0x7E → DATA=0x00007E; GAP of 50 cycles with SCK=0 between bytes.
- START pulsed again mid-transaction, with CMD changed to 0x55 → ignored; the current transaction completes with the original CMD.
- Reset asserted during the second byte → in the same cycle SS=1, SCK=0, BUSY=0, DATA=0. The next START runs a clean transaction.
- Back-to-back: START held high → a second transaction begins 1 cycle after DONE; DATA updates only at each DONE.
